// File: rtl/fio_stream_loader.sv
// fio_stream_loader
//   Byte-stream host front end for the gpu_top_checking FileIO ports. A host
//   sends framed commands (opcode, 16-bit little-endian word count, payload).
//   The block assembles the payload into words and writes them into the TM,
//   ICache, MEM or CLE BRAMs. It can also start a kernel and wait for it to
//   finish, pulse the TM clear, and dump MEM lines back to the host.
//
//   Ports
//     clk / rst                      clock, async active-low reset
//     in_valid/in_data/in_ready      host byte stream in (valid/ready)
//     out_valid/out_data/out_ready   response byte stream out (valid/ready)
//     *_FIO_TM                       TM write, kernel start level, clear pulse
//     finished_TM_FIO                kernel finished
//     *_FIO_ICache                   instruction BRAM write port
//     *_FIO_MEM / Dout_FIO_MEM       MEM write port and 1-cycle-latency read port
//     *_FIO_CLE                      CLE BRAM write port
//     error                          sticky flag, set by an unknown opcode
module fio_stream_loader #(
    parameter int MEM_DEPTH    = 256,
    parameter int SHMEM_DEPTH  = 256,
    parameter int ICACHE_DEPTH = 1024
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic                                       in_valid,
    input  logic [7:0]                                 in_data,
    output logic                                       in_ready,
    output logic                                       out_valid,
    output logic [7:0]                                 out_data,
    input  logic                                       out_ready,
    output logic                                       Wen_FIO_TM,
    output logic [28:0]                                Din_FIO_TM,
    output logic                                       start_FIO_TM,
    output logic                                       clear_FIO_TM,
    input  logic                                       finished_TM_FIO,
    output logic                                       Wen_FIO_ICache,
    output logic [$clog2(ICACHE_DEPTH)-1:0]            Addr_FIO_ICache,
    output logic [31:0]                                Din_FIO_ICache,
    output logic                                       Wen_FIO_MEM,
    output logic [$clog2(MEM_DEPTH+SHMEM_DEPTH)-1:0]   Addr_FIO_MEM,
    output logic [255:0]                               Din_FIO_MEM,
    input  logic [255:0]                               Dout_FIO_MEM,
    output logic                                       Wen_FIO_CLE,
    output logic [$clog2(MEM_DEPTH)-1:0]               Addr_FIO_CLE,
    output logic [4:0]                                 Din_FIO_CLE,
    output logic                                       error
);
    localparam int MEM_TOT = MEM_DEPTH + SHMEM_DEPTH;
    localparam int MEM_AW  = $clog2(MEM_TOT);
    localparam int CLE_AW  = $clog2(MEM_DEPTH);
    localparam int IC_AW   = $clog2(ICACHE_DEPTH);

    localparam logic [2:0] OP_TM = 3'd1, OP_IC = 3'd2, OP_MEM = 3'd3,
                           OP_CLE = 3'd4, OP_DUMP = 3'd6;

    typedef enum logic [3:0] {
        S_IDLE, S_CNT_LO, S_CNT_HI, S_LOAD_BYTES, S_LOAD_WRITE, S_START,
        S_ACK, S_CLEAR, S_DUMP_ADDR, S_DUMP_CAP, S_DUMP_SEND
    } state_t;

    state_t         r_state;
    logic           r_live;     // keeps in_ready low while reset is held
    logic [2:0]     r_op;
    logic [15:0]    r_left;     // words still to load / dump
    logic [15:0]    r_idx;      // word index inside the target
    logic [4:0]     r_bcnt;     // byte position inside the current word
    logic [255:0]   r_word;     // word being assembled, or the line being dumped

    logic           w_acc;
    logic [255:0]   w_word;
    logic [4:0]     w_bpw_last;
    logic [15:0]    w_idx_last;
    logic [15:0]    w_idx_nx;

    assign in_ready = r_live && (r_state == S_IDLE || r_state == S_CNT_LO ||
                                 r_state == S_CNT_HI || r_state == S_LOAD_BYTES);
    assign w_acc    = in_valid && in_ready;

    // Current word with the incoming byte dropped into its little-endian slot.
    always_comb begin
        w_word = r_word;
        w_word[{r_bcnt, 3'b000} +: 8] = in_data;
    end

    always_comb begin
        w_bpw_last = 5'd3;
        w_idx_last = 16'hFFFF;    // TM has no address, index never wraps
        case (r_op)
            OP_IC:           w_idx_last = 16'(ICACHE_DEPTH - 1);
            OP_MEM, OP_DUMP: begin
                w_bpw_last = 5'd31;
                w_idx_last = 16'(MEM_TOT - 1);
            end
            OP_CLE: begin
                w_bpw_last = 5'd0;
                w_idx_last = 16'(MEM_DEPTH - 1);
            end
            default: ;
        endcase
    end

    // Index wraps modulo the target depth, silently.
    assign w_idx_nx = (r_idx == w_idx_last) ? 16'd0 : r_idx + 16'd1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state         <= S_IDLE;
            r_live          <= 1'b0;
            r_op            <= 3'd0;
            r_left          <= 16'd0;
            r_idx           <= 16'd0;
            r_bcnt          <= 5'd0;
            r_word          <= '0;
            out_valid       <= 1'b0;
            out_data        <= 8'd0;
            Wen_FIO_TM      <= 1'b0;
            Din_FIO_TM      <= '0;
            start_FIO_TM    <= 1'b0;
            clear_FIO_TM    <= 1'b0;
            Wen_FIO_ICache  <= 1'b0;
            Addr_FIO_ICache <= '0;
            Din_FIO_ICache  <= '0;
            Wen_FIO_MEM     <= 1'b0;
            Addr_FIO_MEM    <= '0;
            Din_FIO_MEM     <= '0;
            Wen_FIO_CLE     <= 1'b0;
            Addr_FIO_CLE    <= '0;
            Din_FIO_CLE     <= '0;
            error           <= 1'b0;
        end else begin
            r_live         <= 1'b1;
            // Strobes are single-cycle unless re-armed below.
            Wen_FIO_TM     <= 1'b0;
            Wen_FIO_ICache <= 1'b0;
            Wen_FIO_MEM    <= 1'b0;
            Wen_FIO_CLE    <= 1'b0;
            clear_FIO_TM   <= 1'b0;
            case (r_state)
                S_IDLE: if (w_acc) begin
                    r_op   <= in_data[2:0];
                    r_idx  <= 16'd0;
                    r_bcnt <= 5'd0;
                    case (in_data)
                        8'h01, 8'h02, 8'h03, 8'h04, 8'h06: r_state <= S_CNT_LO;
                        8'h05: begin
                            start_FIO_TM <= 1'b1;
                            r_state      <= S_START;
                        end
                        8'h07: begin
                            clear_FIO_TM <= 1'b1;
                            r_state      <= S_CLEAR;
                        end
                        default: error <= 1'b1;
                    endcase
                end
                S_CNT_LO: if (w_acc) begin
                    r_left[7:0] <= in_data;
                    r_state     <= S_CNT_HI;
                end
                S_CNT_HI: if (w_acc) begin
                    r_left[15:8] <= in_data;
                    if ({in_data, r_left[7:0]} == 16'd0) begin
                        r_state <= S_IDLE;
                    end else if (r_op == OP_DUMP) begin
                        Addr_FIO_MEM <= '0;
                        r_state      <= S_DUMP_ADDR;
                    end else begin
                        r_state <= S_LOAD_BYTES;
                    end
                end
                S_LOAD_BYTES: if (w_acc) begin
                    r_word <= w_word;
                    if (r_bcnt == w_bpw_last) begin
                        r_state <= S_LOAD_WRITE;
                        case (r_op)
                            OP_TM: begin
                                Wen_FIO_TM <= 1'b1;
                                Din_FIO_TM <= w_word[28:0];
                            end
                            OP_IC: begin
                                Wen_FIO_ICache  <= 1'b1;
                                Addr_FIO_ICache <= r_idx[IC_AW-1:0];
                                Din_FIO_ICache  <= w_word[31:0];
                            end
                            OP_MEM: begin
                                Wen_FIO_MEM  <= 1'b1;
                                Addr_FIO_MEM <= r_idx[MEM_AW-1:0];
                                Din_FIO_MEM  <= w_word;
                            end
                            OP_CLE: begin
                                Wen_FIO_CLE  <= 1'b1;
                                Addr_FIO_CLE <= r_idx[CLE_AW-1:0];
                                Din_FIO_CLE  <= w_word[4:0];
                            end
                            default: ;
                        endcase
                    end else begin
                        r_bcnt <= r_bcnt + 5'd1;
                    end
                end
                S_LOAD_WRITE: begin
                    r_bcnt  <= 5'd0;
                    r_idx   <= w_idx_nx;
                    r_left  <= r_left - 16'd1;
                    r_state <= (r_left == 16'd1) ? S_IDLE : S_LOAD_BYTES;
                end
                S_START: if (finished_TM_FIO) begin
                    start_FIO_TM <= 1'b0;
                    out_valid    <= 1'b1;
                    out_data     <= 8'hA5;
                    r_state      <= S_ACK;
                end
                S_ACK: if (out_ready) begin
                    out_valid <= 1'b0;
                    r_state   <= S_IDLE;
                end
                S_CLEAR:     r_state <= S_IDLE;
                // Address is on the bus this cycle; data comes back next cycle.
                S_DUMP_ADDR: r_state <= S_DUMP_CAP;
                S_DUMP_CAP: begin
                    out_valid <= 1'b1;
                    out_data  <= Dout_FIO_MEM[7:0];
                    r_word    <= Dout_FIO_MEM >> 8;
                    r_bcnt    <= 5'd0;
                    r_state   <= S_DUMP_SEND;
                end
                S_DUMP_SEND: if (out_ready) begin
                    if (r_bcnt == 5'd31) begin
                        out_valid <= 1'b0;
                        r_left    <= r_left - 16'd1;
                        r_idx     <= w_idx_nx;
                        if (r_left == 16'd1) begin
                            r_state <= S_IDLE;
                        end else begin
                            Addr_FIO_MEM <= w_idx_nx[MEM_AW-1:0];
                            r_state      <= S_DUMP_ADDR;
                        end
                    end else begin
                        r_bcnt   <= r_bcnt + 5'd1;
                        out_data <= r_word[7:0];
                        r_word   <= r_word >> 8;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule
